// File: rtl/rs485_bus_sched_if.sv
// Requester, UART TX and transceiver-control signals of one RS485 channel scheduler.
`timescale 1ns/1ps
interface rs485_bus_sched_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] utx_data;
    logic       utx_valid;
    logic       utx_ready;
    logic       rs485_de;
    logic       rx_en;
    logic [1:0] grant;
    logic       abort_pulse;

    modport master (
        output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, utx_ready,
        input  req0_ready, req1_ready, utx_data, utx_valid, rs485_de, rx_en, grant, abort_pulse
    );

    modport slave (
        input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, utx_ready,
        output req0_ready, req1_ready, utx_data, utx_valid, rs485_de, rx_en, grant, abort_pulse
    );
endinterface

// File: rtl/rs485_bus_sched.sv
// Round-robin frame scheduler sharing one RS485 UART TX and DE pin between two requesters.
// Optional RS485_SCHED_RX_MASK_EN: rx_en low while DE is high and for one cycle after it falls.
`timescale 1ns/1ps
module rs485_bus_sched #(
    parameter int DE_LEAD_CYC = 200,
    parameter int DE_LAG_CYC  = 400,
    parameter int MAX_GAP_CYC = 20000
) (
    input  logic             i_sys_clk,
    input  logic             i_rst,
    rs485_bus_sched_if.slave bus
);
    localparam int MAX_AB = (DE_LEAD_CYC > DE_LAG_CYC) ? DE_LEAD_CYC : DE_LAG_CYC;
    localparam int MAXP   = (MAX_AB > MAX_GAP_CYC) ? MAX_AB : MAX_GAP_CYC;
    localparam int CW     = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] C_ZERO     = '0;
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_SAT      = {CW{1'b1}};
    localparam logic [CW-1:0] C_LEAD_END = CW'(DE_LEAD_CYC - 1);
    localparam logic [CW-1:0] C_LAG_END  = CW'(DE_LAG_CYC - 1);
    localparam logic [CW-1:0] C_GAP_END  = CW'(MAX_GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_LAG   = 3'd4
    } state_t;

    state_t        r_state, w_state_nx;
    logic [1:0]    r_grant, w_grant_nx;
    logic          r_rr, w_rr_nx;       // 0: req0 wins the next contest
    logic          r_de, w_de_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [CW-1:0] r_gap, w_gap_nx;
    logic          r_abort, w_abort_nx;

    logic          w_gv, w_gl;
    logic [7:0]    w_gd;
    logic [CW-1:0] w_cnt_inc, w_gap_inc;
    logic          w_utx_valid, w_rdy0, w_rdy1;
    logic [7:0]    w_utx_data;

    assign w_gv      = r_grant[1] ? bus.req1_valid : bus.req0_valid;
    assign w_gl      = r_grant[1] ? bus.req1_last  : bus.req0_last;
    assign w_gd      = r_grant[1] ? bus.req1_data  : bus.req0_data;
    assign w_cnt_inc = (r_cnt == C_SAT) ? r_cnt : r_cnt + C_ONE;
    assign w_gap_inc = (r_gap == C_SAT) ? r_gap : r_gap + C_ONE;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_rr    <= 1'b0;
            r_de    <= 1'b0;
            r_cnt   <= C_ZERO;
            r_gap   <= C_ZERO;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_rr    <= w_rr_nx;
            r_de    <= w_de_nx;
            r_cnt   <= w_cnt_nx;
            r_gap   <= w_gap_nx;
            r_abort <= w_abort_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_grant_nx  = r_grant;
        w_rr_nx     = r_rr;
        w_de_nx     = r_de;
        w_cnt_nx    = r_cnt;
        w_gap_nx    = r_gap;
        w_abort_nx  = 1'b0;
        w_utx_valid = 1'b0;
        w_utx_data  = 8'h00;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    w_state_nx = ST_LEAD;
                    w_de_nx    = 1'b1;
                    w_cnt_nx   = C_ZERO;
                    w_gap_nx   = C_ZERO;
                    if (bus.req0_valid && bus.req1_valid) begin
                        w_grant_nx = r_rr ? 2'b10 : 2'b01;
                        w_rr_nx    = ~r_rr;
                    end else begin
                        w_grant_nx = bus.req1_valid ? 2'b10 : 2'b01;
                    end
                end
            end
            ST_LEAD: begin
                if (r_cnt == C_LEAD_END) begin
                    w_state_nx = ST_SEND;
                    w_cnt_nx   = C_ZERO;
                    w_gap_nx   = C_ZERO;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            ST_SEND: begin
                w_utx_valid = w_gv;
                w_utx_data  = w_gd;
                w_rdy0      = r_grant[0] & bus.utx_ready;
                w_rdy1      = r_grant[1] & bus.utx_ready;
                if (w_gv && bus.utx_ready) begin
                    w_gap_nx = C_ZERO;
                    if (w_gl) begin
                        w_state_nx = ST_DRAIN;
                        w_cnt_nx   = C_ZERO;
                    end
                end else if (!w_gv) begin
                    // The requester keeps ownership of the unsent tail of an aborted frame.
                    if (r_gap == C_GAP_END) begin
                        w_state_nx = ST_DRAIN;
                        w_cnt_nx   = C_ZERO;
                        w_abort_nx = 1'b1;
                    end else begin
                        w_gap_nx = w_gap_inc;
                    end
                end
            end
            ST_DRAIN: begin
                // utx_ready can still show idle in the cycle right after the last handshake.
                if (r_cnt == C_ZERO) begin
                    w_cnt_nx = C_ONE;
                end else if (bus.utx_ready) begin
                    w_state_nx = ST_LAG;
                    w_cnt_nx   = C_ZERO;
                end
            end
            ST_LAG: begin
                if (r_cnt == C_LAG_END) begin
                    w_state_nx = ST_IDLE;
                    w_de_nx    = 1'b0;
                    w_grant_nx = 2'b00;
                    w_cnt_nx   = C_ZERO;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_de_nx    = 1'b0;
                w_grant_nx = 2'b00;
            end
        endcase
    end

    assign bus.utx_valid   = w_utx_valid;
    assign bus.utx_data    = w_utx_data;
    assign bus.req0_ready  = w_rdy0;
    assign bus.req1_ready  = w_rdy1;
    assign bus.rs485_de    = r_de;
    assign bus.grant       = r_grant;
    assign bus.abort_pulse = r_abort;

`ifdef RS485_SCHED_RX_MASK_EN
    logic r_de_d;
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) r_de_d <= 1'b0;
        else       r_de_d <= r_de;
    end
    assign bus.rx_en = ~(r_de | r_de_d);
`else
    assign bus.rx_en = 1'b1;
`endif
endmodule

// File: tb/tb_rs485_bus_sched.sv
// Bench for rs485_bus_sched: directed sequences, a pass-through vector table and a random run vs a frame-level model.
`timescale 1ns/1ps
module tb_rs485_bus_sched;
    localparam int LEAD = 4;
    localparam int LAG  = 6;
    localparam int GAP  = 8;
`ifdef RS485_SCHED_RX_MASK_EN
    localparam bit RX_MASK = 1'b1;
`else
    localparam bit RX_MASK = 1'b0;
`endif
    localparam int P_IDLE = 0, P_LEAD = 1, P_SEND = 2, P_DRAIN = 3, P_LAG = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rs485_bus_sched_if bus ();

    rs485_bus_sched #(.DE_LEAD_CYC(LEAD), .DE_LAG_CYC(LAG), .MAX_GAP_CYC(GAP)) dut (
        .i_sys_clk(clk),
        .i_rst    (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_uv(input string nm, output int n);
        #1;
        n = 0;
        while (!bus.utx_valid && n < 200) begin step(); n++; end
        if (!bus.utx_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_de_low(input string nm, output int n);
        #1;
        n = 0;
        while (bus.rs485_de && n < 200) begin step(); n++; end
        if (bus.rs485_de) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Frame-level reference: phase plus down-counters, evaluated from the current inputs each cycle.
    int         m_phase = P_IDLE, m_owner = -1, m_pref = 0, m_left = 0, m_gap = 0;
    bit         m_first = 1'b0, m_abort = 1'b0, m_dep = 1'b0;
    logic       gv, gl, e_de, e_send, e_uv, e_r0, e_r1, e_rx;
    logic [7:0] gd, e_ud;
    logic [1:0] e_grant;

    always @(negedge clk) begin
        gv      = (m_owner == 1) ? bus.req1_valid : bus.req0_valid;
        gl      = (m_owner == 1) ? bus.req1_last  : bus.req0_last;
        gd      = (m_owner == 1) ? bus.req1_data  : bus.req0_data;
        e_de    = (m_phase != P_IDLE);
        e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        e_send  = (m_phase == P_SEND);
        e_uv    = e_send && gv;
        e_ud    = e_send ? gd : 8'h00;
        e_r0    = e_send && (m_owner == 0) && bus.utx_ready;
        e_r1    = e_send && (m_owner == 1) && bus.utx_ready;
        e_rx    = RX_MASK ? !(e_de || m_dep) : 1'b1;
        chk("model",
            {16'h0, bus.rs485_de, bus.grant, bus.utx_valid, bus.utx_data, bus.req0_ready,
             bus.req1_ready, bus.abort_pulse, bus.rx_en},
            {16'h0, e_de, e_grant, e_uv, e_ud, e_r0, e_r1, m_abort, e_rx});
        if (rst) begin
            m_phase = P_IDLE; m_owner = -1; m_pref = 0; m_abort = 1'b0; m_dep = 1'b0;
        end else begin
            m_dep   = e_de;
            m_abort = 1'b0;
            case (m_phase)
                P_IDLE: if (bus.req0_valid || bus.req1_valid) begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        m_owner = m_pref;
                        m_pref  = 1 - m_pref;
                    end else begin
                        m_owner = bus.req1_valid ? 1 : 0;
                    end
                    m_phase = P_LEAD;
                    m_left  = LEAD;
                end
                P_LEAD: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_SEND; m_gap = 0; end
                end
                P_SEND: begin
                    if (gv && bus.utx_ready) begin
                        m_gap = 0;
                        if (gl) begin m_phase = P_DRAIN; m_first = 1'b1; end
                    end else if (!gv) begin
                        m_gap++;
                        if (m_gap == GAP) begin m_phase = P_DRAIN; m_first = 1'b1; m_abort = 1'b1; end
                    end
                end
                P_DRAIN: begin
                    if (m_first) m_first = 1'b0;
                    else if (bus.utx_ready) begin m_phase = P_LAG; m_left = LAG; end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_IDLE; m_owner = -1; end
                end
            endcase
        end
    end

    typedef struct packed {
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       rdy;
        logic       uv;
        logic [7:0] ud;
        logic       r0;
        logic       r1;
    } vec_t;

    vec_t       tbl [6];
    logic [7:0] t1_bytes [3];
    logic [1:0] t2_grant [3];
    int         n, viol, pulses, at, sent, dens;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // SEND pass-through with req0 owning the bus; req1 must stay invisible.
        tbl[0] = '{1'b1, 8'h81, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h82, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h82, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h83, 1'b0, 1'b1, 8'hC4, 1'b1, 1'b0, 8'h83, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h90, 1'b1, 1'b1, 8'hC5, 1'b1, 1'b0, 8'h90, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'h84, 1'b0, 1'b1, 8'hC6, 1'b1, 1'b1, 8'h84, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'h85, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h85, 1'b0, 1'b0};
        t1_bytes[0] = 8'hA5; t1_bytes[1] = 8'h5A; t1_bytes[2] = 8'hFF;
        t2_grant[0] = 2'b01; t2_grant[1] = 2'b10; t2_grant[2] = 2'b01;

        bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
        bus.utx_ready  = 1'b0;
        repeat (3) step();
        chk("rst_de", bus.rs485_de, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_outs", {bus.utx_valid, bus.req0_ready, bus.req1_ready, bus.abort_pulse}, 0);
        chk("rst_rx", bus.rx_en, 1);

        // Three-byte frame from req0 with a busy UART between bytes.
        rst = 1'b0;
        step();
        bus.utx_ready = 1'b1; bus.req0_valid = 1'b1; bus.req0_data = t1_bytes[0];
        step();
        chk("t1_de_rise", bus.rs485_de, 1);
        chk("t1_grant", bus.grant, 2'b01);
        chk("t1_rx_mask", bus.rx_en, !RX_MASK);
        wait_uv("t1_lead", n);
        chk("t1_lead_len", n, LEAD);
        for (int i = 0; i < 3; i++) begin
            wait_uv("t1_byte", n);
            chk($sformatf("t1_byte%0d", i), bus.utx_data, t1_bytes[i]);
            step();
            bus.utx_ready = 1'b0;
            if (i < 2) begin
                bus.req0_data = t1_bytes[i+1];
                bus.req0_last = (i == 1);
            end else begin
                bus.req0_valid = 1'b0;
                bus.req0_last  = 1'b0;
            end
            repeat (3) step();
            bus.utx_ready = 1'b1;
        end
        wait_de_low("t1_lag", n);
        chk("t1_lag_len", n, LAG + 1);
        chk("t1_rx_after", bus.rx_en, !RX_MASK);
        step();
        chk("t1_rx_idle", bus.rx_en, 1);

        // Three back-to-back contests.
        bus.req0_data = 8'h11; bus.req1_data = 8'h22;
        bus.req0_last = 1'b1;  bus.req1_last = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_de_low("t2_idle", n);
            chk($sformatf("t2_idle_grant%0d", k), bus.grant, 0);
            step();
            chk($sformatf("t2_grant%0d", k), bus.grant, t2_grant[k]);
            wait_uv("t2_send", n);
            chk($sformatf("t2_data%0d", k), bus.utx_data, (t2_grant[k] == 2'b01) ? 8'h11 : 8'h22);
            step();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_de_low("t2_end", n);

        // req0 shows up while req1 owns the bus.
        bus.req1_valid = 1'b1; bus.req1_data = 8'h33; bus.req1_last = 1'b0;
        step();
        chk("t3_grant1", bus.grant, 2'b10);
        bus.req0_valid = 1'b1; bus.req0_data = 8'h44; bus.req0_last = 1'b1;
        viol = 0; sent = 0; n = 0;
        while (n < 200) begin
            #1;
            if (!bus.rs485_de) break;
            if (bus.req0_ready || (bus.utx_valid && bus.utx_data == 8'h44)) viol++;
            if (bus.utx_valid && bus.req1_ready) begin
                step();
                sent++;
                if (sent == 1) begin bus.req1_data = 8'h34; bus.req1_last = 1'b1; end
                else begin bus.req1_valid = 1'b0; bus.req1_last = 1'b0; end
            end else begin
                step();
            end
            n++;
        end
        chk("t3_r0_blocked", viol, 0);
        chk("t3_req1_bytes", sent, 2);
        step();
        chk("t3_grant0", bus.grant, 2'b01);
        wait_uv("t3_send", n);
        chk("t3_data", bus.utx_data, 8'h44);
        step();
        bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
        wait_de_low("t3_end", n);

        // One byte then silence: gap abort.
        bus.req0_valid = 1'b1; bus.req0_data = 8'h55;
        step();
        wait_uv("t4_send", n);
        step();
        bus.req0_valid = 1'b0;
        pulses = 0; at = -1;
        for (int k = 1; k <= GAP + LAG + 12; k++) begin
            step();
            if (bus.abort_pulse) begin pulses++; if (at < 0) at = k; end
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_pulse_at", at, GAP);
        chk("t4_de", bus.rs485_de, 0);
        chk("t4_grant", bus.grant, 0);

        // Pass-through vector table.
        bus.req0_valid = 1'b1; bus.req0_data = 8'h70; bus.utx_ready = 1'b0;
        step();
        wait_uv("tbl_send", n);
        for (int i = 0; i < 6; i++) begin
            bus.req0_valid = tbl[i].v0; bus.req0_data = tbl[i].d0; bus.req0_last = tbl[i].l0;
            bus.req1_valid = tbl[i].v1; bus.req1_data = tbl[i].d1; bus.utx_ready = tbl[i].rdy;
            #2;
            chk($sformatf("tbl%0d", i), {bus.utx_valid, bus.utx_data, bus.req0_ready, bus.req1_ready},
                {tbl[i].uv, tbl[i].ud, tbl[i].r0, tbl[i].r1});
            step();
        end
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_last = 1'b1; bus.utx_ready = 1'b1;
        step();
        bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
        wait_de_low("tbl_end", n);

        // Reset in the middle of SEND.
        bus.req0_valid = 1'b1; bus.req0_data = 8'h66; bus.utx_ready = 1'b0;
        step();
        wait_uv("t5_send", n);
        rst = 1'b1;
        step();
        chk("t5_de", bus.rs485_de, 0);
        chk("t5_uv", bus.utx_valid, 0);
        chk("t5_grant", bus.grant, 0);
        rst = 1'b0;
        step();
        chk("t5_restart", bus.rs485_de, 1);
        wait_uv("t5_lead", n);
        chk("t5_lead_len", n, LEAD);
        bus.req0_last = 1'b1; bus.utx_ready = 1'b1;
        step();
        bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
        wait_de_low("t5_end", n);

        // Random traffic against the model.
        dens = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: dens = 15;
                    1: dens = 70;
                    default: dens = 95;
                endcase
            end
            bus.req0_valid = ($urandom_range(0, 99) < dens);
            bus.req1_valid = ($urandom_range(0, 99) < dens);
            bus.req0_data  = 8'($urandom_range(0, 255));
            bus.req1_data  = 8'($urandom_range(0, 255));
            bus.req0_last  = ($urandom_range(0, 3) == 0);
            bus.req1_last  = ($urandom_range(0, 3) == 0);
            bus.utx_ready  = $urandom_range(0, 1) == 1;
            rst            = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.utx_ready = 1'b1;
        repeat (LEAD + LAG + GAP + 10) step();
        chk("final_de", bus.rs485_de, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
